qnigma_icmp_echo_ctl: RTL and testbench
=======================================

QNIGMA_ICMP_ECHO_CTL -- requirements
Module: qnigma_icmp_echo_ctl

Interface
REQ-001 Parameter MAX_LEN, 1472, maximum accepted echo payload length in bytes.
REQ-002 Parameter TMO_CYC, 1000000, cycles to wait in WAIT_ACK or SEND before abort (QNIGMA_ICMP_ECHO_TMO_EN only).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 rx_sof  in  1  echo request header accepted; rx_id/rx_seq valid this cycle.
REQ-006 rx_id, rx_seq  in  16 each  identifier and sequence of the request.
REQ-007 vin  in  1  payload byte valid (din not needed; bytes go to FIFO and accumulator directly).
REQ-008 ful  in  1  payload FIFO full.
REQ-009 rx_eof  in  1  frame ended good; rx_err  in  1  frame ended bad (CRC/length).
REQ-010 cks_in  in  32  running payload sum from the checksum accumulator, including odd-byte padding.
REQ-011 cks_rst  out  1  accumulator clear; fifo_clr  out  1  payload FIFO flush pulse.
REQ-012 tx_req  out  1  reply ready; tx_ack  in  1  TX accepted; tx_done  in  1  TX finished reading the FIFO.
REQ-013 tx_len  out  16  payload bytes; tx_id, tx_seq  out  16  echoed; tx_cks  out  16  ICMP reply checksum.
REQ-014 busy  out  1  high in any state other than IDLE; drop_cnt  out  8  saturating count of dropped requests.

Function
REQ-015 States: IDLE, RECV, SUM, FOLD1, FOLD2, WAIT_ACK, SEND; all outputs registered.
REQ-016 IDLE: cks_rst=1; on rx_sof, latch rx_id/rx_seq, clear the byte counter, set cks_rst=0, go to RECV; vin in the rx_sof cycle is not counted.
REQ-017 RECV: counter increments on vin && !ful; rx_eof with counter <= MAX_LEN goes to SUM.
REQ-018 RECV drop conditions: vin && ful, counter would exceed MAX_LEN, or rx_err; on drop pulse fifo_clr for 1 cycle, increment drop_cnt (saturate at 255), return to IDLE.
REQ-019 rx_eof and rx_err in the same cycle: rx_err wins (drop).
REQ-020 rx_eof must not coincide with the last vin; the source guarantees at least one cycle between them.
REQ-021 SUM (1 cycle): s <= cks_in + rx_id + rx_seq, 32-bit; type/code of the reply are 0 and contribute nothing.
REQ-022 FOLD1: s <= s[15:0] + s[31:16]; FOLD2: s <= s[15:0] + s[16]; then tx_cks <= ~s[15:0] and go to WAIT_ACK.
REQ-023 Latency from rx_eof to tx_req high: 4 cycles.
REQ-024 WAIT_ACK: tx_req=1 and tx_len/tx_id/tx_seq/tx_cks are stable; on tx_ack set tx_req=0 and go to SEND.
REQ-025 SEND: on tx_done pulse fifo_clr and cks_rst for 1 cycle and go to IDLE; busy falls in the same cycle.
REQ-026 rx_sof outside IDLE is ignored and increments drop_cnt; rx_sof in the cycle busy falls is also dropped.
REQ-027 A zero-length payload is legal: tx_len=0 and tx_cks=~(id+seq folded).
REQ-028 tx_ack in the same cycle as tx_done while in WAIT_ACK: take only tx_ack; tx_done is ignored outside SEND.

Reset
REQ-029 In any state, rst forces IDLE on the next edge.
REQ-030 Reset values: cks_rst=1; fifo_clr=1 during rst; tx_req=0; busy=0; drop_cnt=0; tx_len, tx_id, tx_seq and tx_cks = 0.
REQ-031 Reset during WAIT_ACK or SEND drops tx_req immediately and does not count as a drop.

Configuration
REQ-032 Macro QNIGMA_ICMP_ECHO_TMO_EN defined: a cycle counter runs in WAIT_ACK and SEND and clears on each state entry.
REQ-033 When that counter reaches TMO_CYC-1: pulse fifo_clr, increment drop_cnt, go to IDLE.
REQ-034 Macro not defined: no timeout counter; WAIT_ACK and SEND wait indefinitely; TMO_CYC is unused.

Verification
REQ-035 id=0x0001, seq=0x0002, payload 61 62 63 64, rx_eof -> tx_len=4, tx_cks=0x3B36, tx_req 4 cycles after rx_eof.
REQ-036 id=0x0001, seq=0x0002, payload 61 62 63 (odd) -> tx_len=3, tx_cks=0x3B9A.
REQ-037 id=0x0000, seq=0x0001, payload FF FF FF FF -> both folds exercised, tx_cks=0xFFFE.
REQ-038 ful=1 with vin mid-payload -> fifo_clr pulse, drop_cnt=1, IDLE, no tx_req; next request completes normally.
REQ-039 rx_sof in WAIT_ACK -> ignored, drop_cnt increments, pending reply unchanged; tx_ack then tx_done -> IDLE.
REQ-040 With QNIGMA_ICMP_ECHO_TMO_EN, TMO_CYC=16, tx_ack withheld -> abort exactly 16 cycles after WAIT_ACK entry, drop_cnt=1.

Source files
------------

// File: rtl/qnigma_icmp_echo_ctl.sv
// qnigma_icmp_echo_ctl
// Control path for ICMP echo replies. It counts payload bytes, builds the reply
// checksum from the external payload accumulator plus identifier and sequence,
// then hands the reply to the transmitter and waits for it to drain the FIFO.
// Requests that are malformed, overflow, or arrive while busy are counted in a
// saturating drop counter.
// Optional feature: define QNIGMA_ICMP_ECHO_TMO_EN to abort a reply that stays
// in WAIT_ACK or SEND for TMO_CYC cycles.
module qnigma_icmp_echo_ctl #(
  parameter int MAX_LEN = 1472,
  parameter int TMO_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_sof,
  input  logic [15:0] rx_id,
  input  logic [15:0] rx_seq,
  input  logic        vin,
  input  logic        ful,
  input  logic        rx_eof,
  input  logic        rx_err,
  input  logic [31:0] cks_in,
  output logic        cks_rst,
  output logic        fifo_clr,
  output logic        tx_req,
  input  logic        tx_ack,
  input  logic        tx_done,
  output logic [15:0] tx_len,
  output logic [15:0] tx_id,
  output logic [15:0] tx_seq,
  output logic [15:0] tx_cks,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RECV     = 3'd1;
  localparam logic [2:0] SUM      = 3'd2;
  localparam logic [2:0] FOLD1    = 3'd3;
  localparam logic [2:0] FOLD2    = 3'd4;
  localparam logic [2:0] WAIT_ACK = 3'd5;
  localparam logic [2:0] SEND     = 3'd6;

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  logic [2:0]    state;
  logic [2:0]    state_nx;
  logic [LW-1:0] byte_cnt;
  logic [15:0]   id_q;
  logic [15:0]   seq_q;
  logic [31:0]   s;
  logic [15:0]   fold2;
  logic          recv_drop;
  logic          tx_fin;
  logic          tmo_abort;
  logic          sof_ign;
  logic          tmo_hit;
  logic [1:0]    drop_inc;
  logic [8:0]    drop_sum;

  // The second fold can never carry out, so 16 bits hold the final sum.
  assign fold2 = s[15:0] + {15'd0, s[16]};

  // Every event that costs a request adds to the counter; the sum saturates.
  assign drop_inc = {1'b0, recv_drop | tmo_abort} + {1'b0, sof_ign};
  assign drop_sum = {1'b0, drop_cnt} + {7'd0, drop_inc};

`ifdef QNIGMA_ICMP_ECHO_TMO_EN
  localparam int TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  // Cycle counter for the reply handshake; it restarts on every state entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if ((state_nx != state) || !((state == WAIT_ACK) || (state == SEND))) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign unused_tmo = (TMO_CYC == 0);
`endif

  // Next-state decision plus the single-cycle events that drive the outputs.
  always_comb begin
    state_nx  = state;
    recv_drop = 1'b0;
    tx_fin    = 1'b0;
    tmo_abort = 1'b0;
    sof_ign   = rx_sof && (state != IDLE);
    case (state)
      IDLE: begin
        if (rx_sof) state_nx = RECV;
      end
      RECV: begin
        if (rx_err || (vin && (ful || (byte_cnt == LEN_MAX)))) begin
          recv_drop = 1'b1;
          state_nx  = IDLE;
        end else if (rx_eof) begin
          state_nx = SUM;
        end
      end
      SUM:   state_nx = FOLD1;
      FOLD1: state_nx = FOLD2;
      FOLD2: state_nx = WAIT_ACK;
      WAIT_ACK: begin
        if (tx_ack) begin
          state_nx = SEND;
        end else if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_nx  = IDLE;
        end
      end
      SEND: begin
        if (tx_done) begin
          tx_fin   = 1'b1;
          state_nx = IDLE;
        end else if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register and registered control outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      cks_rst  <= 1'b1;
      fifo_clr <= 1'b1;
      tx_req   <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      state    <= state_nx;
      busy     <= (state_nx != IDLE);
      cks_rst  <= (state_nx == IDLE);
      fifo_clr <= recv_drop | tx_fin | tmo_abort;
      tx_req   <= (state_nx == WAIT_ACK);
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  // Datapath: request header capture, byte count, checksum fold and reply fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q     <= 16'd0;
      seq_q    <= 16'd0;
      byte_cnt <= '0;
      s        <= 32'd0;
      tx_len   <= 16'd0;
      tx_id    <= 16'd0;
      tx_seq   <= 16'd0;
      tx_cks   <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_sof) begin
            id_q     <= rx_id;
            seq_q    <= rx_seq;
            byte_cnt <= '0;
          end
        end
        RECV: begin
          if (vin && !ful && (byte_cnt != LEN_MAX)) byte_cnt <= byte_cnt + 1'b1;
        end
        SUM: begin
          s <= cks_in + {16'd0, id_q} + {16'd0, seq_q};
        end
        FOLD1: begin
          s <= {16'd0, s[15:0]} + {16'd0, s[31:16]};
        end
        FOLD2: begin
          s      <= {16'd0, fold2};
          tx_cks <= ~fold2;
          tx_len <= 16'(byte_cnt);
          tx_id  <= id_q;
          tx_seq <= seq_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qnigma_icmp_echo_ctl.sv
// tb_qnigma_icmp_echo_ctl
// Directed bench for qnigma_icmp_echo_ctl. A transaction-level reference keeps
// the received bytes in a queue and computes the reply checksum with
// end-around-carry arithmetic; a compare process checks every cycle against it.
module tb_qnigma_icmp_echo_ctl;

  localparam int MAX_LEN = 8;
  localparam int TMO_CYC = 16;

  logic        clk;
  logic        rst;
  logic        rx_sof;
  logic [15:0] rx_id;
  logic [15:0] rx_seq;
  logic        vin;
  logic        ful;
  logic        rx_eof;
  logic        rx_err;
  logic [31:0] cks_in;
  logic        cks_rst;
  logic        fifo_clr;
  logic        tx_req;
  logic        tx_ack;
  logic        tx_done;
  logic [15:0] tx_len;
  logic [15:0] tx_id;
  logic [15:0] tx_seq;
  logic [15:0] tx_cks;
  logic        busy;
  logic [7:0]  drop_cnt;

  logic [7:0]  cur_byte;
  logic [7:0]  stim_bytes[$];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          chk_en = 0;

  qnigma_icmp_echo_ctl #(.MAX_LEN(MAX_LEN), .TMO_CYC(TMO_CYC)) dut (
    .clk(clk), .rst(rst), .rx_sof(rx_sof), .rx_id(rx_id), .rx_seq(rx_seq),
    .vin(vin), .ful(ful), .rx_eof(rx_eof), .rx_err(rx_err), .cks_in(cks_in),
    .cks_rst(cks_rst), .fifo_clr(fifo_clr), .tx_req(tx_req), .tx_ack(tx_ack),
    .tx_done(tx_done), .tx_len(tx_len), .tx_id(tx_id), .tx_seq(tx_seq),
    .tx_cks(tx_cks), .busy(busy), .drop_cnt(drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state.
  typedef enum int {M_IDLE, M_RECV, M_CALC, M_WAIT, M_SEND} mmode_t;
  mmode_t      m_mode = M_IDLE;
  logic [7:0]  m_bytes[$];
  logic [15:0] m_id, m_seq;
  int          m_wait, m_tmo, m_drop;
  logic        e_tx_req, e_fifo_clr;
  logic [15:0] e_len, e_id, e_seq, e_cks;

  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] t;
    t = {1'b0, a} + {1'b0, b};
    return t[15:0] + {15'd0, t[16]};
  endfunction

  function automatic logic [15:0] model_cks();
    logic [15:0] acc;
    logic [15:0] w;
    int n;
    n = m_bytes.size();
    acc = oc_add(m_id, m_seq);
    for (int i = 0; i < n; i += 2) begin
      w[15:8] = m_bytes[i];
      w[7:0]  = (i + 1 < n) ? m_bytes[i + 1] : 8'h00;
      acc = oc_add(acc, w);
    end
    return ~acc;
  endfunction

  // Behavioural reference: request lifecycle with a byte queue and drop rules.
  always @(posedge clk) begin
    int inc;
    if (rst) begin
      m_mode = M_IDLE; m_drop = 0; e_tx_req = 1'b0; e_fifo_clr = 1'b1;
      e_len = 16'd0; e_id = 16'd0; e_seq = 16'd0; e_cks = 16'd0;
      m_bytes.delete();
    end else begin
      inc = 0;
      e_fifo_clr = 1'b0;
      if (rx_sof && m_mode != M_IDLE) inc++;
      case (m_mode)
        M_IDLE: if (rx_sof) begin
          m_id = rx_id; m_seq = rx_seq; m_bytes.delete(); m_mode = M_RECV;
        end
        M_RECV: begin
          if (rx_err || (vin && (ful || m_bytes.size() == MAX_LEN))) begin
            inc++; e_fifo_clr = 1'b1; m_mode = M_IDLE;
          end else if (rx_eof) begin
            m_mode = M_CALC; m_wait = 3;
          end else if (vin) begin
            m_bytes.push_back(cur_byte);
          end
        end
        M_CALC: begin
          m_wait--;
          if (m_wait == 0) begin
            m_mode = M_WAIT; m_tmo = 0; e_tx_req = 1'b1;
            e_len = 16'(m_bytes.size()); e_id = m_id; e_seq = m_seq; e_cks = model_cks();
          end
        end
        M_WAIT: begin
          if (tx_ack) begin
            m_mode = M_SEND; m_tmo = 0; e_tx_req = 1'b0;
          end
`ifdef QNIGMA_ICMP_ECHO_TMO_EN
          else if (m_tmo == TMO_CYC - 1) begin
            inc++; e_fifo_clr = 1'b1; e_tx_req = 1'b0; m_mode = M_IDLE;
          end else m_tmo++;
`endif
        end
        M_SEND: begin
          if (tx_done) begin
            e_fifo_clr = 1'b1; m_mode = M_IDLE;
          end
`ifdef QNIGMA_ICMP_ECHO_TMO_EN
          else if (m_tmo == TMO_CYC - 1) begin
            inc++; e_fifo_clr = 1'b1; m_mode = M_IDLE;
          end else m_tmo++;
`endif
        end
        default: m_mode = M_IDLE;
      endcase
      m_drop = (m_drop + inc > 255) ? 255 : m_drop + inc;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  // Cycle-by-cycle comparison of the DUT against the reference.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("tx_req", {31'd0, tx_req}, {31'd0, e_tx_req});
      checkOutput("busy", {31'd0, busy}, {31'd0, m_mode != M_IDLE});
      checkOutput("cks_rst", {31'd0, cks_rst}, {31'd0, m_mode == M_IDLE});
      checkOutput("fifo_clr", {31'd0, fifo_clr}, {31'd0, e_fifo_clr});
      checkOutput("drop_cnt", {24'd0, drop_cnt}, 32'(m_drop));
      if (e_tx_req) begin
        checkOutput("tx_len", {16'd0, tx_len}, {16'd0, e_len});
        checkOutput("tx_id", {16'd0, tx_id}, {16'd0, e_id});
        checkOutput("tx_seq", {16'd0, tx_seq}, {16'd0, e_seq});
        checkOutput("tx_cks", {16'd0, tx_cks}, {16'd0, e_cks});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one request (stim_bytes as payload) and reports cycles from end to tx_req.
  task automatic applyStimulus(input logic [15:0] id, input logic [15:0] seq, input int ful_at,
                               input int end_kind, input bit vin_at_sof, output int lat);
    cks_in = 32'd0;
    rx_sof = 1'b1; rx_id = id; rx_seq = seq; vin = vin_at_sof; cur_byte = 8'hEE;
    tick();
    rx_sof = 1'b0; vin = 1'b0;
    for (int i = 0; i < stim_bytes.size(); i++) begin
      vin = 1'b1; cur_byte = stim_bytes[i]; ful = (i == ful_at);
      tick();
      if (i == ful_at) break;
      if (i % 2 == 0) cks_in = cks_in + {16'd0, stim_bytes[i], 8'h00};
      else            cks_in = cks_in + {24'd0, stim_bytes[i]};
    end
    vin = 1'b0; ful = 1'b0;
    tick();
    lat = -1;
    if (ful_at < 0) begin
      rx_eof = (end_kind != 1); rx_err = (end_kind != 0); lat = 0;
      do begin
        tick();
        rx_eof = 1'b0; rx_err = 1'b0;
        lat++;
      end while (!tx_req && lat < 12);
    end
  endtask

  task automatic finishReply();
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    checkOutput("ack_req_low", {31'd0, tx_req}, 32'd0);
    checkOutput("send_busy", {31'd0, busy}, 32'd1);
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checkOutput("done_busy", {31'd0, busy}, 32'd0);
    checkOutput("done_fifo_clr", {31'd0, fifo_clr}, 32'd1);
    tick();
  endtask

  initial begin
    int lat;
    rst = 1'b1; rx_sof = 0; rx_id = 0; rx_seq = 0; vin = 0; ful = 0;
    rx_eof = 0; rx_err = 0; cks_in = 0; tx_ack = 0; tx_done = 0; cur_byte = 0;
    @(posedge clk);
    #1 chk_en = 1;
    repeat (2) tick();
    checkOutput("rst_tx_req", {31'd0, tx_req}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_cks_rst", {31'd0, cks_rst}, 32'd1);
    checkOutput("rst_fifo_clr", {31'd0, fifo_clr}, 32'd1);
    checkOutput("rst_drop", {24'd0, drop_cnt}, 32'd0);
    checkOutput("rst_len", {16'd0, tx_len}, 32'd0);
    checkOutput("rst_cks", {16'd0, tx_cks}, 32'd0);
    checkOutput("rst_id", {16'd0, tx_id}, 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_fifo_clr", {31'd0, fifo_clr}, 32'd0);

    $display("[TB] even payload");
    stim_bytes = '{8'h61, 8'h62, 8'h63, 8'h64};
    applyStimulus(16'h0001, 16'h0002, -1, 0, 1'b0, lat);
    checkOutput("even_latency", 32'(lat), 32'd4);
    checkOutput("even_len", {16'd0, tx_len}, 32'd4);
    checkOutput("even_cks", {16'd0, tx_cks}, 32'h3B36);
    checkOutput("even_seq", {16'd0, tx_seq}, 32'h0002);
    finishReply();

    $display("[TB] odd payload, vin during sof");
    stim_bytes = '{8'h61, 8'h62, 8'h63};
    applyStimulus(16'h0001, 16'h0002, -1, 0, 1'b1, lat);
    checkOutput("odd_len", {16'd0, tx_len}, 32'd3);
    checkOutput("odd_cks", {16'd0, tx_cks}, 32'h3B9A);
    finishReply();

    $display("[TB] double fold");
    stim_bytes = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    applyStimulus(16'h0000, 16'h0001, -1, 0, 1'b0, lat);
    checkOutput("fold_cks", {16'd0, tx_cks}, 32'hFFFE);
    finishReply();

    $display("[TB] full FIFO drop then zero-length request");
    stim_bytes = '{8'h61, 8'h62, 8'h63, 8'h64};
    applyStimulus(16'h0005, 16'h0006, 2, 0, 1'b0, lat);
    repeat (3) tick();
    checkOutput("ful_drop", {24'd0, drop_cnt}, 32'd1);
    checkOutput("ful_no_req", {31'd0, tx_req}, 32'd0);
    stim_bytes.delete();
    applyStimulus(16'h1234, 16'h5678, -1, 0, 1'b0, lat);
    checkOutput("zero_latency", 32'(lat), 32'd4);
    checkOutput("zero_len", {16'd0, tx_len}, 32'd0);
    checkOutput("zero_cks", {16'd0, tx_cks}, 32'h9753);
    finishReply();

    $display("[TB] frame errors");
    stim_bytes = '{8'h10, 8'h20};
    applyStimulus(16'h0007, 16'h0008, -1, 1, 1'b0, lat);
    checkOutput("err_drop", {24'd0, drop_cnt}, 32'd2);
    applyStimulus(16'h0007, 16'h0009, -1, 2, 1'b0, lat);
    checkOutput("err_eof_drop", {24'd0, drop_cnt}, 32'd3);
    checkOutput("err_no_req", 32'(lat), 32'd12);

    $display("[TB] length boundary");
    stim_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    applyStimulus(16'h0000, 16'h0000, -1, 0, 1'b0, lat);
    checkOutput("max_len", {16'd0, tx_len}, 32'd8);
    checkOutput("max_cks", {16'd0, tx_cks}, 32'hEFEB);
    finishReply();
    stim_bytes.push_back(8'h09);
    applyStimulus(16'h0000, 16'h0000, -1, 0, 1'b0, lat);
    checkOutput("over_drop", {24'd0, drop_cnt}, 32'd4);

    $display("[TB] sof while busy");
    stim_bytes = '{8'h61, 8'h62, 8'h63, 8'h64};
    applyStimulus(16'h0001, 16'h0002, -1, 0, 1'b0, lat);
    rx_sof = 1'b1; rx_id = 16'hAAAA; rx_seq = 16'hBBBB;
    tick();
    rx_sof = 1'b0;
    checkOutput("wait_sof_drop", {24'd0, drop_cnt}, 32'd5);
    checkOutput("wait_sof_req", {31'd0, tx_req}, 32'd1);
    checkOutput("wait_sof_cks", {16'd0, tx_cks}, 32'h3B36);
    checkOutput("wait_sof_id", {16'd0, tx_id}, 32'h0001);
    tx_ack = 1'b1; tx_done = 1'b1;
    tick();
    tx_ack = 1'b0; tx_done = 1'b0;
    checkOutput("ack_done_busy", {31'd0, busy}, 32'd1);
    tick();
    tx_done = 1'b1; rx_sof = 1'b1;
    tick();
    tx_done = 1'b0; rx_sof = 1'b0;
    checkOutput("fall_sof_drop", {24'd0, drop_cnt}, 32'd6);
    checkOutput("fall_busy", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("fall_stay_idle", {31'd0, busy}, 32'd0);

    $display("[TB] drop counter saturation");
    rx_sof = 1'b1; rx_id = 16'h0003; rx_seq = 16'h0004;
    repeat (260) tick();
    rx_sof = 1'b0; rx_err = 1'b1;
    tick();
    rx_err = 1'b0;
    tick();
    checkOutput("drop_sat", {24'd0, drop_cnt}, 32'd255);

    $display("[TB] reset during reply");
    stim_bytes = '{8'h61, 8'h62};
    applyStimulus(16'h0001, 16'h0002, -1, 0, 1'b0, lat);
    rst = 1'b1;
    tick();
    checkOutput("mid_rst_req", {31'd0, tx_req}, 32'd0);
    checkOutput("mid_rst_drop", {24'd0, drop_cnt}, 32'd0);
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();

`ifdef QNIGMA_ICMP_ECHO_TMO_EN
    $display("[TB] handshake timeout");
    stim_bytes.delete();
    applyStimulus(16'h0001, 16'h0002, -1, 0, 1'b0, lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (tx_req && lat < 40);
    checkOutput("tmo_cycles", 32'(lat), 32'd16);
    checkOutput("tmo_drop", {24'd0, drop_cnt}, 32'd1);
    checkOutput("tmo_busy", {31'd0, busy}, 32'd0);
    tick();
`endif

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
